// File: rtl/deal_controller.sv
// deal_controller: deals cards 1..52 from a virtual deck without repeats.
// Each request pulses the shared RNG, waits out its latency and checks the
// drawn value against a dealt bitmap. Collisions are redrawn a bounded
// number of times. After that, linear probing from the last draw finds a
// free card, so every request finishes in bounded time.
module deal_controller #(
  parameter int RNG_LAT   = 2,  // cycles from rng_next falling edge to a stable rng_value
  parameter int MAX_RETRY = 4   // fresh draws per request before linear probing (>= 1)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        deal_req,
  input  logic        new_deck,
  input  logic [15:0] rng_value,
  output logic        rng_next,
  output logic [5:0]  card,
  output logic        deal_valid,
  output logic        deal_err,
  output logic        busy,
  output logic [5:0]  cards_left,
  output logic        deck_empty
);

  localparam int DECK = 52;
  localparam int WCW  = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;
  localparam int RCW  = $clog2(MAX_RETRY + 1);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(RNG_LAT - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT,
    ST_CHECK,
    ST_PROBE
  } state_e;

  state_e           state_q, state_d;
  logic [DECK-1:0]  bitmap_q, bitmap_d;     // 1 = card already dealt
  logic [5:0]       cards_left_q, cards_left_d;
  logic [5:0]       card_q, card_d;
  logic [5:0]       cand_q, cand_d;         // current probe candidate, 1..52
  logic [RCW-1:0]   retry_q, retry_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             rng_next_q, rng_next_d;
  logic             deal_valid_q, deal_valid_d;
  logic             deal_err_q, deal_err_d;

  // Decision signals shared by the next-state and datapath logic
  logic             deck_empty_w;
  logic             rng_in_range;
  logic [5:0]       rng_card;
  logic [5:0]       rng_slot;
  logic [5:0]       cand_slot;
  logic [63:0]      taken_vec;
  logic             rng_free;
  logic             cand_free;
  logic [RCW-1:0]   retry_inc;
  logic [5:0]       probe_start;
  logic [5:0]       cand_next;
  logic             deal_fire;
  logic [5:0]       deal_card;
  logic             err_fire;
  logic [DECK-1:0]  set_mask;

  assign deck_empty_w = (cards_left_q == 6'd0);

  // The whole 16-bit value takes part in the range test, so a large draw
  // whose low bits happen to look like a card still counts as a miss.
  assign rng_in_range = (rng_value >= 16'd1) && (rng_value <= 16'd52);
  assign rng_card     = rng_value[5:0];
  assign rng_slot     = rng_card - 6'd1;
  assign cand_slot    = cand_q - 6'd1;

  // Padding the bitmap to 64 entries lets any 6-bit slot index it safely;
  // the unused slots read back as taken.
  assign taken_vec = {12'hFFF, bitmap_q};
  assign rng_free  = rng_in_range && !taken_vec[rng_slot];
  assign cand_free = !taken_vec[cand_slot];

  assign retry_inc = retry_q + RCW'(1);

  // Probing starts one past the last draw, or at card 1 when the draw was
  // unusable or was card 52.
  assign probe_start = (rng_in_range && (rng_card != 6'd52)) ? (rng_card + 6'd1) : 6'd1;
  assign cand_next   = (cand_q == 6'd52) ? 6'd1 : (cand_q + 6'd1);

  // One-hot mask of the card being dealt this cycle
  generate
    for (genvar gi = 0; gi < DECK; gi++) begin : g_set_mask
      assign set_mask[gi] = deal_fire && (deal_card == 6'(gi + 1));
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; new_deck overrides every state and returns to IDLE
  always_comb begin
    state_d = state_q;
    if (new_deck) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deal_req && !deck_empty_w) begin
            state_d = ST_PULSE;
          end
        end
        ST_PULSE: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rng_free) begin
            state_d = ST_IDLE;
          end else if (retry_inc < RETRY_MAX) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (cand_free) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decision: which card, if any, is dealt this cycle, or an empty-deck error
  always_comb begin
    deal_fire = 1'b0;
    deal_card = 6'd0;
    err_fire  = 1'b0;
    if (!new_deck) begin
      case (state_q)
        ST_IDLE: begin
          err_fire = deal_req && deck_empty_w;
        end
        ST_CHECK: begin
          if (rng_free) begin
            deal_fire = 1'b1;
            deal_card = rng_card;
          end
        end
        ST_PROBE: begin
          if (cand_free) begin
            deal_fire = 1'b1;
            deal_card = cand_q;
          end
        end
        default: begin
          deal_fire = 1'b0;
        end
      endcase
    end
  end

  // Datapath next values: deck bookkeeping, retry/wait counters, probe candidate
  always_comb begin
    bitmap_d     = bitmap_q | set_mask;
    cards_left_d = deal_fire ? (cards_left_q - 6'd1) : cards_left_q;
    card_d       = deal_fire ? deal_card : card_q;
    retry_d      = retry_q;
    wait_cnt_d   = wait_cnt_q;
    cand_d       = cand_q;
    if (new_deck) begin
      bitmap_d     = '0;
      cards_left_d = 6'd52;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deal_req && !deck_empty_w) begin
            retry_d = '0;
          end
        end
        ST_PULSE: begin
          wait_cnt_d = WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WCW'(1);
          end
        end
        ST_CHECK: begin
          if (!rng_free) begin
            retry_d = retry_inc;
            cand_d  = probe_start;
          end
        end
        ST_PROBE: begin
          if (!cand_free) begin
            cand_d = cand_next;
          end
        end
        default: begin
          cand_d = cand_q;
        end
      endcase
    end
    // rng_next is high exactly while the FSM sits in PULSE; PULSE always
    // leaves after one cycle, so the RNG never sees two adjacent high cycles.
    rng_next_d   = (state_d == ST_PULSE);
    deal_valid_d = deal_fire;
    deal_err_d   = err_fire;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bitmap_q     <= '0;
      cards_left_q <= 6'd52;
      card_q       <= 6'd0;
      cand_q       <= 6'd1;
      retry_q      <= '0;
      wait_cnt_q   <= '0;
      rng_next_q   <= 1'b0;
      deal_valid_q <= 1'b0;
      deal_err_q   <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      cards_left_q <= cards_left_d;
      card_q       <= card_d;
      cand_q       <= cand_d;
      retry_q      <= retry_d;
      wait_cnt_q   <= wait_cnt_d;
      rng_next_q   <= rng_next_d;
      deal_valid_q <= deal_valid_d;
      deal_err_q   <= deal_err_d;
    end
  end

  assign rng_next   = rng_next_q;
  assign card       = card_q;
  assign deal_valid = deal_valid_q;
  assign deal_err   = deal_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign cards_left = cards_left_q;
  assign deck_empty = deck_empty_w;

endmodule

// File: tb/tb_deal_controller.sv
// tb_deal_controller: directed tests for deal_controller with a queue-driven RNG stub.
module tb_deal_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        deal_req = 1'b0;
  logic        new_deck = 1'b0;
  logic [15:0] rng_value = 16'd0;
  logic        rng_next;
  logic [5:0]  card;
  logic        deal_valid;
  logic        deal_err;
  logic        busy;
  logic [5:0]  cards_left;
  logic        deck_empty;

  int checks = 0;
  int errors = 0;

  logic [15:0] stub_q[$];
  int          pulse_cnt = 0;

  always #5 clk = ~clk;

  deal_controller #(.RNG_LAT(2), .MAX_RETRY(4)) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .deal_req   (deal_req),
    .new_deck   (new_deck),
    .rng_value  (rng_value),
    .rng_next   (rng_next),
    .card       (card),
    .deal_valid (deal_valid),
    .deal_err   (deal_err),
    .busy       (busy),
    .cards_left (cards_left),
    .deck_empty (deck_empty)
  );

  // RNG stub: each rng_next pulse presents the next queued value
  always @(negedge clk) begin
    if (rng_next === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      if (stub_q.size() > 0) rng_value = stub_q.pop_front();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request, then wait (bounded) for deal_valid; cyc counts edges after the sampling edge
  task automatic run_deal(output logic [5:0] got, output int cyc);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    cyc = 0;
    while (deal_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    got = card;
    $display("deal: card=%0d cycles=%0d cards_left=%0d", got, cyc, cards_left);
  endtask

  task automatic pulse_new_deck();
    new_deck = 1'b1;
    tick();
    new_deck = 1'b0;
  endtask

  task automatic test_reset();
    string      nm  [7];
    logic [7:0] obs [7];
    logic [7:0] exp [7];
    reset_n = 1'b0;
    repeat (3) tick();
    nm[0] = "rst_card";       obs[0] = {2'b0, card};        exp[0] = 8'd0;
    nm[1] = "rst_cards_left"; obs[1] = {2'b0, cards_left};  exp[1] = 8'd52;
    nm[2] = "rst_deck_empty"; obs[2] = {7'b0, deck_empty};  exp[2] = 8'd0;
    nm[3] = "rst_busy";       obs[3] = {7'b0, busy};        exp[3] = 8'd0;
    nm[4] = "rst_rng_next";   obs[4] = {7'b0, rng_next};    exp[4] = 8'd0;
    nm[5] = "rst_deal_valid"; obs[5] = {7'b0, deal_valid};  exp[5] = 8'd0;
    nm[6] = "rst_deal_err";   obs[6] = {7'b0, deal_err};    exp[6] = 8'd0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", nm[i], obs[i], exp[i]);
      end
    end
    reset_n = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_basic();
    int pc0;
    stub_q.delete();
    stub_q.push_back(16'd17);
    pc0 = pulse_cnt;
    deal_req = 1'b1;
    tick();  // edge 0
    deal_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got=%0b exp=1", busy); end
    checks++; if (rng_next !== 1'b1) begin errors++; $display("FAIL basic_rng_next_e0 got=%0b exp=1", rng_next); end
    tick();  // edge 1
    checks++; if (rng_next !== 1'b0) begin errors++; $display("FAIL basic_rng_next_e1 got=%0b exp=0", rng_next); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e1 got=%0b exp=1", busy); end
    tick();  // edge 2
    tick();  // edge 3
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e3 got=%0b exp=1", busy); end
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b exp=0", deal_valid); end
    tick();  // edge 4
    checks++; if (deal_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_e4 got=%0b exp=1", deal_valid); end
    checks++; if (card !== 6'd17) begin errors++; $display("FAIL basic_card got=%0d exp=17", card); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL basic_cards_left got=%0d exp=51", cards_left); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_e4 got=%0b exp=0", busy); end
    tick();
    tick();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got=%0b exp=0", deal_valid); end
    checks++; if (card !== 6'd17) begin errors++; $display("FAIL basic_card_hold got=%0d exp=17", card); end
    checks++; if (pulse_cnt - pc0 !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulse_cnt - pc0); end
    $display("basic: card=%0d cards_left=%0d", card, cards_left);
  endtask

  task automatic test_collision_probe();
    logic [5:0] got;
    int         cyc, pc0;
    stub_q.delete();
    repeat (4) stub_q.push_back(16'd17);
    pc0 = pulse_cnt;
    run_deal(got, cyc);
    checks++; if (got !== 6'd18) begin errors++; $display("FAIL coll_card got=%0d exp=18", got); end
    checks++; if (cyc !== 17) begin errors++; $display("FAIL coll_latency got=%0d exp=17", cyc); end
    checks++; if (pulse_cnt - pc0 !== 4) begin errors++; $display("FAIL coll_pulses got=%0d exp=4", pulse_cnt - pc0); end
    checks++; if (cards_left !== 6'd50) begin errors++; $display("FAIL coll_cards_left got=%0d exp=50", cards_left); end
  endtask

  task automatic test_out_of_range();
    logic [5:0] got;
    int         cyc, pc0;
    stub_q.delete();
    stub_q.push_back(16'd0);
    stub_q.push_back(16'd60);
    stub_q.push_back(16'd5);
    pc0 = pulse_cnt;
    run_deal(got, cyc);
    checks++; if (got !== 6'd5) begin errors++; $display("FAIL oor_card got=%0d exp=5", got); end
    checks++; if (cyc !== 12) begin errors++; $display("FAIL oor_latency got=%0d exp=12", cyc); end
    checks++; if (pulse_cnt - pc0 !== 3) begin errors++; $display("FAIL oor_pulses got=%0d exp=3", pulse_cnt - pc0); end
    // all zero draws: probing starts at card 1
    stub_q.delete();
    repeat (4) stub_q.push_back(16'd0);
    run_deal(got, cyc);
    checks++; if (got !== 6'd1) begin errors++; $display("FAIL oor_zero_card got=%0d exp=1", got); end
    checks++; if (cyc !== 17) begin errors++; $display("FAIL oor_zero_latency got=%0d exp=17", cyc); end
    // 0x0142 has low bits 2 but is out of range and must be redrawn
    stub_q.delete();
    stub_q.push_back(16'h0142);
    stub_q.push_back(16'd3);
    run_deal(got, cyc);
    checks++; if (got !== 6'd3) begin errors++; $display("FAIL oor_upper_card got=%0d exp=3", got); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL oor_upper_latency got=%0d exp=8", cyc); end
    checks++; if (cards_left !== 6'd47) begin errors++; $display("FAIL oor_cards_left got=%0d exp=47", cards_left); end
  endtask

  task automatic test_probe_wrap();
    logic [5:0] got;
    int         cyc;
    pulse_new_deck();
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL wrap_new_deck got=%0d exp=52", cards_left); end
    stub_q.delete();
    stub_q.push_back(16'd52);
    run_deal(got, cyc);
    checks++; if (got !== 6'd52) begin errors++; $display("FAIL wrap_first got=%0d exp=52", got); end
    stub_q.delete();
    repeat (4) stub_q.push_back(16'd52);
    run_deal(got, cyc);
    checks++; if (got !== 6'd1) begin errors++; $display("FAIL wrap_card got=%0d exp=1", got); end
    checks++; if (cyc !== 17) begin errors++; $display("FAIL wrap_latency got=%0d exp=17", cyc); end
    stub_q.delete();
    stub_q.push_back(16'd51);
    run_deal(got, cyc);
    checks++; if (got !== 6'd51) begin errors++; $display("FAIL wrap_51 got=%0d exp=51", got); end
    // probe 52 (taken) -> 1 (taken) -> 2
    stub_q.delete();
    repeat (4) stub_q.push_back(16'd51);
    run_deal(got, cyc);
    checks++; if (got !== 6'd2) begin errors++; $display("FAIL wrap_multi_card got=%0d exp=2", got); end
    checks++; if (cyc !== 19) begin errors++; $display("FAIL wrap_multi_latency got=%0d exp=19", cyc); end
    checks++; if (cards_left !== 6'd48) begin errors++; $display("FAIL wrap_cards_left got=%0d exp=48", cards_left); end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_new_deck();
    stub_q.delete();
    stub_q.push_back(16'd20);
    stub_q.push_back(16'd21);
    deal_req = 1'b1;
    tick();  // edge 0
    n = 0;
    while (deal_valid !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", n); end
    checks++; if (card !== 6'd20) begin errors++; $display("FAIL b2b_first_card got=%0d exp=20", card); end
    n = 0;
    tick();
    while (deal_valid !== 1'b1 && n < 50) begin tick(); n++; end
    deal_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_second_gap got=%0d exp=4", n); end
    checks++; if (card !== 6'd21) begin errors++; $display("FAIL b2b_second_card got=%0d exp=21", card); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
    checks++; if (cards_left !== 6'd50) begin errors++; $display("FAIL b2b_cards_left got=%0d exp=50", cards_left); end
    $display("back_to_back: cards 20,21 cards_left=%0d", cards_left);
  endtask

  task automatic test_exhaust();
    logic [5:0] got;
    int         cyc, pc0;
    pulse_new_deck();
    for (int i = 1; i <= 52; i++) begin
      stub_q.delete();
      stub_q.push_back(16'(i));
      run_deal(got, cyc);
      checks++;
      if (got !== 6'(i) || cyc !== 4) begin
        errors++;
        $display("FAIL exhaust_deal got=%0d/%0d exp=%0d/4", got, cyc, i);
      end
    end
    checks++; if (cards_left !== 6'd0) begin errors++; $display("FAIL exhaust_cards_left got=%0d exp=0", cards_left); end
    checks++; if (deck_empty !== 1'b1) begin errors++; $display("FAIL exhaust_deck_empty got=%0b exp=1", deck_empty); end
    pc0 = pulse_cnt;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    checks++; if (deal_err !== 1'b1) begin errors++; $display("FAIL exhaust_err got=%0b exp=1", deal_err); end
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL exhaust_valid got=%0b exp=0", deal_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exhaust_busy got=%0b exp=0", busy); end
    tick();
    checks++; if (deal_err !== 1'b0) begin errors++; $display("FAIL exhaust_err_width got=%0b exp=0", deal_err); end
    tick();
    checks++; if (pulse_cnt - pc0 !== 0) begin errors++; $display("FAIL exhaust_pulses got=%0d exp=0", pulse_cnt - pc0); end
    $display("exhaust: deal_err seen, cards_left=%0d", cards_left);
  endtask

  task automatic test_new_deck_abort();
    logic [5:0] got;
    int         cyc, pc0, seen;
    pulse_new_deck();
    stub_q.delete();
    stub_q.push_back(16'd7);
    run_deal(got, cyc);
    // new_deck with deal_req in the same IDLE cycle: request ignored
    pc0 = pulse_cnt;
    new_deck = 1'b1;
    deal_req = 1'b1;
    tick();
    new_deck = 1'b0;
    deal_req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nd_ignore_busy got=%0b exp=0", busy); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL nd_ignore_cards_left got=%0d exp=52", cards_left); end
    tick();
    checks++; if (pulse_cnt - pc0 !== 0) begin errors++; $display("FAIL nd_ignore_pulses got=%0d exp=0", pulse_cnt - pc0); end
    stub_q.delete();
    stub_q.push_back(16'd8);
    run_deal(got, cyc);
    // abort during WAIT
    stub_q.delete();
    stub_q.push_back(16'd10);
    deal_req = 1'b1;
    tick();  // edge 0 -> PULSE
    deal_req = 1'b0;
    tick();  // edge 1 -> WAIT
    new_deck = 1'b1;
    tick();  // edge 2 -> IDLE
    new_deck = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    checks++; if (rng_next !== 1'b0) begin errors++; $display("FAIL abort_rng_next got=%0b exp=0", rng_next); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL abort_cards_left got=%0d exp=52", cards_left); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (deal_valid === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
    // card 8 was dealt before new_deck; it must be available again
    stub_q.delete();
    stub_q.push_back(16'd8);
    run_deal(got, cyc);
    checks++; if (got !== 6'd8 || cyc !== 4) begin errors++; $display("FAIL abort_redeal got=%0d/%0d exp=8/4", got, cyc); end
  endtask

  task automatic test_reset_mid_probe();
    logic [5:0] got;
    int         cyc;
    pulse_new_deck();
    stub_q.delete();
    stub_q.push_back(16'd17);
    run_deal(got, cyc);
    stub_q.delete();
    repeat (4) stub_q.push_back(16'd17);
    deal_req = 1'b1;
    tick();  // edge 0
    deal_req = 1'b0;
    repeat (16) tick();  // edge 16 -> PROBE
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_probe_busy got=%0b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%0b exp=0", busy); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL async_cards_left got=%0d exp=52", cards_left); end
    checks++; if (card !== 6'd0) begin errors++; $display("FAIL async_card got=%0d exp=0", card); end
    checks++; if (deal_valid !== 1'b0 || rng_next !== 1'b0 || deal_err !== 1'b0) begin
      errors++;
      $display("FAIL async_pulses got=%0b%0b%0b exp=000", deal_valid, rng_next, deal_err);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (deal_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%0b exp=0", deal_valid); end
    $display("reset_mid_probe: cards_left=%0d", cards_left);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision_probe();
    test_out_of_range();
    test_probe_wrap();
    test_back_to_back();
    test_exhaust();
    test_new_deck_abort();
    test_reset_mid_probe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
